// File: rtl/bcd_seq_conv.sv
// bcd_seq_conv: sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// A shared per-digit correction datapath is stepped over the WIDTH-bit operand by
// a three-state controller (IDLE -> SHIFT x WIDTH -> DONE -> IDLE).
// Optional build macro: BCD_SEQ_HEX_EN adds a registered active-low 7-segment output
// (HexOut) per digit, updated together with BCDOut.

// Per-digit correction lane: add 3 when the digit is 5 or more (4-bit, no carry out).
module bcd_seq_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bcd_seq_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    input  logic                  Start,
    input  logic [WIDTH-1:0]      BinIn,
    output logic                  Busy,
    output logic                  Done,
`ifdef BCD_SEQ_HEX_EN
    output logic [7*DIGITS-1:0]   HexOut,
`endif
    output logic [4*DIGITS-1:0]   BCDOut
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t                    state, state_nxt;
    logic [DIGITS-1:0][3:0]    bcd;
    logic [DIGITS-1:0][3:0]    bcd_adj;
    logic [4*DIGITS-1:0]       bcd_adj_flat;
    logic [4*DIGITS-1:0]       bcd_shift;
    logic [WIDTH-1:0]          bin;
    logic [CW-1:0]             cnt;
    logic                      load;
    logic                      last;

    // One correction lane per BCD digit
    for (genvar i = 0; i < DIGITS; i++) begin : g_lane
        bcd_seq_digit_adj u_adj (
            .din  (bcd[i]),
            .dout (bcd_adj[i])
        );
    end

    // Corrected digits shifted left once, operand MSB entering the ones digit.
    // The top digit MSB falls off; it is always 0 for legal parameters.
    assign bcd_adj_flat = bcd_adj;
    assign bcd_shift    = (bcd_adj_flat << 1) | {{(4*DIGITS-1){1'b0}}, bin[WIDTH-1]};
    assign last         = (cnt == CW'(1));

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state and status decode
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        Busy      = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                Busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shift register and bit counter: load on accepted Start, step once per SHIFT cycle
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            bcd <= '0;
            bin <= '0;
            cnt <= '0;
        end else if (load) begin
            bcd <= '0;
            bin <= BinIn;
            cnt <= CW'(WIDTH);
        end else if (state == S_SHIFT) begin
            bcd <= bcd_shift;
            bin <= bin << 1;
            cnt <= cnt - CW'(1);
        end
    end

    // Result register: captured by the final shift, held until the next one
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)                        BCDOut <= '0;
        else if (state == S_SHIFT && last)  BCDOut <= bcd_shift;
    end

`ifdef BCD_SEQ_HEX_EN
    logic [DIGITS-1:0][6:0] hex_nxt;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    for (genvar i = 0; i < DIGITS; i++) begin : g_hex
        assign hex_nxt[i] = seg7(bcd_shift[4*i +: 4]);
    end

    // Segment register: follows BCDOut, resets to every digit showing 0
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)                        HexOut <= {DIGITS{7'b1000000}};
        else if (state == S_SHIFT && last)  HexOut <= hex_nxt;
    end
`endif

endmodule
